// File: rtl/calc_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_op_sequencer_if
// Purpose  : Bundles the command/result handshake and the shared add/sub unit
//            connection of the calculator op sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface calc_op_sequencer_if #(
    parameter int WIDTH = 4
);
    // command side
    logic                   start;
    logic [1:0]             op;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    // result side
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     result;
    logic                   err;
    // shared add/sub unit
    logic [WIDTH-1:0]       alu_a;
    logic [WIDTH-1:0]       alu_b;
    logic                   alu_sub;
    logic [WIDTH-1:0]       alu_sum;
    logic                   alu_cout;

    // Environment side: issues commands and hosts the add/sub unit.
    modport master (
        output start, op, a, b, alu_sum, alu_cout,
        input  busy, done, result, err, alu_a, alu_b, alu_sub
    );

    // Sequencer side.
    modport slave (
        input  start, op, a, b, alu_sum, alu_cout,
        output busy, done, result, err, alu_a, alu_b, alu_sub
    );
endinterface
`default_nettype wire

// File: rtl/calc_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_op_sequencer
// Purpose  : Drives one shared 4-bit add/sub unit to perform ADD, SUB,
//            shift-add MUL and restoring DIV on unsigned operands, giving an
//            8-bit result with a one-cycle done pulse.
// Revision : 1.0  initial release
// ============================================================================
module calc_op_sequencer #(
    parameter int WIDTH = 4,
    parameter int ITER  = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    calc_op_sequencer_if.slave  bus
);

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_MUL = 2'b10;
    localparam logic [1:0] c_OP_DIV = 2'b11;
    localparam logic [1:0] c_LAST_ITER = 2'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_hi;      // MUL: product high half; DIV: remainder
    logic [WIDTH-1:0]     r_lo;      // MUL: multiplier/product low; DIV: quotient
    logic [1:0]           r_cnt;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_err;

    logic                 w_div0;
    logic                 w_last;
    logic                 w_ok;
    logic [WIDTH-1:0]     w_sh;
    logic [WIDTH-1:0]     w_hi_nxt;
    logic [WIDTH-1:0]     w_lo_nxt;
    logic [2*WIDTH-1:0]   w_res_nxt;
    logic                 w_err_nxt;

    assign w_div0 = (r_b == '0);
    // Partial remainder shifted left with the next dividend bit brought in.
    assign w_sh   = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and add/sub unit operand steering.
    always_comb begin
        w_state_nxt  = r_state;
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        bus.alu_sub  = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_op)
                    c_OP_ADD: begin
                        bus.alu_a = r_a;
                        bus.alu_b = r_b;
                        w_last    = 1'b1;
                    end
                    c_OP_SUB: begin
                        bus.alu_a   = r_a;
                        bus.alu_b   = r_b;
                        bus.alu_sub = 1'b1;
                        w_last      = 1'b1;
                    end
                    c_OP_MUL: begin
                        bus.alu_a = r_hi;
                        bus.alu_b = r_lo[0] ? r_a : '0;
                        w_last    = (r_cnt == c_LAST_ITER);
                    end
                    default: begin
                        // Divide by zero finishes at once and leaves the unit idle.
                        if (w_div0) begin
                            w_last = 1'b1;
                        end else begin
                            bus.alu_a   = w_sh;
                            bus.alu_b   = r_b;
                            bus.alu_sub = 1'b1;
                            w_last      = (r_cnt == c_LAST_ITER);
                        end
                    end
                endcase
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Per-iteration update of the working registers and the final result value.
    always_comb begin
        w_ok      = bus.alu_cout | r_hi[WIDTH-1];
        w_hi_nxt  = r_hi;
        w_lo_nxt  = r_lo;
        w_res_nxt = '0;
        w_err_nxt = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_res_nxt = {{(WIDTH-1){1'b0}}, bus.alu_cout, bus.alu_sum};
            end
            c_OP_SUB: begin
                // Missing carry means a borrow: sign-extend to 8-bit two's complement.
                w_res_nxt = {{WIDTH{~bus.alu_cout}}, bus.alu_sum};
            end
            c_OP_MUL: begin
                w_hi_nxt  = {bus.alu_cout, bus.alu_sum[WIDTH-1:1]};
                w_lo_nxt  = {bus.alu_sum[0], r_lo[WIDTH-1:1]};
                w_res_nxt = {w_hi_nxt, w_lo_nxt};
            end
            default: begin
                // A set top bit in R means the shifted value already exceeds B.
                w_hi_nxt = w_ok ? bus.alu_sum : w_sh;
                w_lo_nxt = {r_lo[WIDTH-2:0], w_ok};
                if (w_div0) begin
                    w_res_nxt = '1;
                    w_err_nxt = 1'b1;
                end else begin
                    w_res_nxt = {w_hi_nxt, w_lo_nxt};
                end
            end
        endcase
    end

    // Command capture, iteration stepping and result registration.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= c_OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op  <= bus.op;
                        r_a   <= bus.a;
                        r_b   <= bus.b;
                        r_hi  <= '0;
                        r_lo  <= (bus.op == c_OP_DIV) ? bus.a : bus.b;
                        r_cnt <= '0;
                    end
                end
                S_EXEC: begin
                    r_hi <= w_hi_nxt;
                    r_lo <= w_lo_nxt;
                    if (w_last) begin
                        r_cnt    <= '0;
                        r_result <= w_res_nxt;
                        r_err    <= w_err_nxt;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;
    assign bus.err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_calc_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_op_sequencer
// Purpose  : Self-checking bench for calc_op_sequencer with a behavioural
//            add/sub unit and an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_calc_op_sequencer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    calc_op_sequencer_if #(.WIDTH(4)) bus ();

    calc_op_sequencer #(.WIDTH(4), .ITER(4)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Shared add/sub unit: subtraction is A + ~B + 1, carry-out = no borrow.
    assign {bus.alu_cout, bus.alu_sum} = {1'b0, bus.alu_a}
                                       + {1'b0, (bus.alu_sub ? ~bus.alu_b : bus.alu_b)}
                                       + {4'b0, bus.alu_sub};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the run ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {err, result} from plain arithmetic.
    function automatic logic [8:0] ref_calc(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int ia;
        int ib;
        int r;
        ia = int'(a);
        ib = int'(b);
        r  = 0;
        case (op)
            2'd0: r = ia + ib;
            2'd1: r = ia - ib;
            2'd2: r = ia * ib;
            default: begin
                if (ib == 0) return {1'b1, 8'hFF};
                r = (ia % ib) * 16 + (ia / ib);
            end
        endcase
        return {1'b0, 8'(r)};
    endfunction

    // Number of EXEC cycles before the done cycle.
    function automatic int ref_lat(input logic [1:0] op, input logic [3:0] b);
        if (op == 2'd2) return 4;
        if (op == 2'd3 && b != 4'd0) return 4;
        return 1;
    endfunction

    // Issue one command and follow it cycle by cycle to completion.
    // poke=1 pulses start with other operands during EXEC and during DONE.
    // spec_res >= 0 additionally compares against a literal expected result.
    task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input bit poke, input int spec_res);
        logic [8:0] exp;
        int         n;
        exp = ref_calc(op, a, b);
        n   = ref_lat(op, b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check("exec_busy", 32'(bus.busy), 32'd1);
            check("exec_done", 32'(bus.done), 32'd0);
            if (op == 2'd2) check("mul_alu_sub", 32'(bus.alu_sub), 32'd0);
            if (poke && i == 0) begin
                bus.start = 1'b1;
                bus.op    = 2'd0;
                bus.a     = ~a;
                bus.b     = ~b;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("done_pulse", 32'(bus.done), 32'd1);
        check("done_busy", 32'(bus.busy), 32'd1);
        check("result", 32'(bus.result), 32'(exp[7:0]));
        check("err", 32'(bus.err), 32'(exp[8]));
        if (spec_res >= 0) check("result_literal", 32'(bus.result), 32'(spec_res));
        if (poke) begin
            bus.start = 1'b1;
            bus.op    = 2'd1;
            bus.a     = a + 4'd3;
            bus.b     = b + 4'd5;
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("result_held", 32'(bus.result), 32'(exp[7:0]));
        check("idle_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_sub}), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_err     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.a     = 4'd0;
        bus.b     = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_sub}), 32'd0);
        rst = 1'b0;

        // Directed arithmetic cases.
        run_op(2'd0, 4'd9,  4'd8,  1'b0, 'h11);
        run_op(2'd0, 4'd15, 4'd15, 1'b0, 'h1E);
        run_op(2'd1, 4'd5,  4'd3,  1'b0, 'h02);
        run_op(2'd1, 4'd3,  4'd5,  1'b0, 'hFE);
        run_op(2'd1, 4'd0,  4'd15, 1'b0, 'hF1);
        run_op(2'd2, 4'd15, 4'd15, 1'b0, 'hE1);
        run_op(2'd2, 4'd7,  4'd0,  1'b0, 'h00);
        run_op(2'd3, 4'd13, 4'd4,  1'b0, 'h13);
        run_op(2'd3, 4'd15, 4'd1,  1'b0, 'h0F);
        run_op(2'd3, 4'd14, 4'd11, 1'b0, 'h31);
        run_op(2'd3, 4'd9,  4'd0,  1'b0, 'hFF);
        check("div0_err_held", 32'(bus.err), 32'd1);
        run_op(2'd3, 4'd8,  4'd2,  1'b0, 'h04);

        // Start pulses while busy are dropped.
        run_op(2'd2, 4'd3,  4'd5,  1'b1, 'h0F);
        run_op(2'd0, 4'd6,  4'd7,  1'b1, 'h0D);

        // Randomized commands against the reference model.
        for (int k = 0; k < 40; k++) begin
            run_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), -1);
        end

        // Abort a MUL with reset in its second EXEC cycle.
        run_op(2'd2, 4'd15, 4'd15, 1'b0, 'hE1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'd2;
        bus.a     = 4'd7;
        bus.b     = 4'd6;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", 32'(bus.result), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 32'd0);
        end

        // start held high: second command taken in the IDLE cycle after DONE.
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.a     = 4'd2;
        bus.b     = 4'd3;
        @(negedge clk);
        check("hold_exec1_busy", 32'(bus.busy), 32'd1);
        check("hold_exec1_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("hold_done1", 32'(bus.done), 32'd1);
        check("hold_res1", 32'(bus.result), 32'h05);
        bus.a = 4'd4;
        bus.b = 4'd5;
        @(negedge clk);
        check("hold_idle_busy", 32'(bus.busy), 32'd0);
        check("hold_idle_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        check("hold_exec2_busy", 32'(bus.busy), 32'd1);
        check("hold_exec2_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("hold_done2", 32'(bus.done), 32'd1);
        check("hold_res2", 32'(bus.result), 32'h09);
        @(negedge clk);
        check("hold_end_busy", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
